// File: rtl/fetch_if.sv
// Fetch-unit handshake and control bundle: harness start/finish, decoder
// controls, jump-LUT write port and the PC/status outputs.
interface fetch_if #(
  parameter int D  = 10,
  parameter int L  = 5,
  parameter int CW = 16
);
  logic          req;
  logic          stall;
  logic          halt_in;
  logic          absjump_en;
  logic          branch_en;
  logic          branch_cond;
  logic [7:0]    rel_off;
  logic [L-1:0]  lut_addr;
  logic          lut_we;
  logic [L-1:0]  lut_waddr;
  logic [D-1:0]  lut_wdata;
  logic [D-1:0]  prog_ctr;
  logic          fetch_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycles;

  modport slave (
    input  req, stall, halt_in, absjump_en, branch_en, branch_cond, rel_off,
           lut_addr, lut_we, lut_waddr, lut_wdata,
    output prog_ctr, fetch_valid, busy, done, cycles
  );

  modport master (
    output req, stall, halt_in, absjump_en, branch_en, branch_cond, rel_off,
           lut_addr, lut_we, lut_waddr, lut_wdata,
    input  prog_ctr, fetch_valid, busy, done, cycles
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the IDLE/RUN/HALT run handshake,
// an absolute jump-target LUT and a saturating RUN-cycle counter.
module fetch_unit #(
  parameter int          D          = 10,
  parameter int          L          = 5,
  parameter int unsigned START_ADDR = 0,
  parameter int          CW         = 16
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.slave bus
);

  localparam int LUT_DEPTH = 1 << L;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        r_state;
  logic [D-1:0]  r_pc;
  logic [CW-1:0] r_cycles;
  logic [D-1:0]  r_lut [LUT_DEPTH];

  logic [D-1:0]  w_lut_rdata;
  logic [D-1:0]  w_rel_sext;
  logic [D-1:0]  w_pc_seq;
  logic [D-1:0]  w_pc_branch;
  logic [D-1:0]  w_pc_next;
  logic [CW-1:0] w_cycles_inc;
  logic          w_run;

  assign w_run = (r_state == S_RUN);

  // NOTE: every signal driven from always_comb gets a default assignment
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_lut_rdata  = r_lut[bus.lut_addr];
    w_rel_sext   = D'($signed(bus.rel_off));
    w_pc_seq     = r_pc + 1'b1;
    w_pc_branch  = r_pc + w_rel_sext;
    w_pc_next    = w_pc_seq;
    if (bus.absjump_en) begin
      w_pc_next = w_lut_rdata;
    end else if (bus.branch_en && bus.branch_cond) begin
      w_pc_next = w_pc_branch;
    end
    w_cycles_inc = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_cycles <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.req) begin
            r_state  <= S_RUN;
            r_pc     <= D'(START_ADDR);
            r_cycles <= '0;
          end
        end
        S_RUN: begin
          // Stalled and halting cycles still count toward the run length.
          r_cycles <= w_cycles_inc;
          if (!bus.stall) begin
            if (bus.halt_in) begin
              r_state <= S_HALT;
            end else begin
              r_pc <= w_pc_next;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the LUT is a register array with a reset because a reset must
  // leave every jump target at 0; a RAM macro could not provide that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_lut[i] <= '0;
      end
    end else if (bus.lut_we) begin
      r_lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  assign bus.prog_ctr    = r_pc;
  assign bus.busy        = w_run;
  assign bus.done        = (r_state == S_HALT);
  assign bus.fetch_valid = w_run & ~bus.stall;
  assign bus.cycles      = r_cycles;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural model pushes expected
// post-edge state to a scoreboard queue that is popped after each edge.
module tb_fetch_unit;
  localparam int D  = 10;
  localparam int L  = 5;
  localparam int CW = 16;

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_HALT} mstate_t;

  typedef struct {
    string         tag;
    logic [D-1:0]  pc;
    logic          busy;
    logic          done;
    logic [CW-1:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if #(.D(D), .L(L), .CW(CW)) bus ();
  fetch_if #(.D(D), .L(L), .CW(4))  bus4 ();

  fetch_unit #(.D(D), .L(L), .START_ADDR(0), .CW(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  fetch_unit #(.D(D), .L(L), .START_ADDR(0), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  exp_t          sb[$];
  mstate_t       m_state;
  logic [D-1:0]  m_pc;
  logic [CW-1:0] m_cyc;
  logic [D-1:0]  m_lut [1 << L];

  task automatic clear_inputs();
    bus.req = 0; bus.stall = 0; bus.halt_in = 0; bus.absjump_en = 0;
    bus.branch_en = 0; bus.branch_cond = 0; bus.rel_off = '0;
    bus.lut_addr = '0; bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_pc = '0; m_cyc = '0;
    for (int i = 0; i < (1 << L); i++) m_lut[i] = '0;
    sb.delete();
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic cycle(input string tag);
    exp_t         e;
    logic         exp_fv;
    logic [D-1:0] sext;
    exp_fv = (m_state == M_RUN) && !bus.stall;
    #1;
    n_tests++;
    if (bus.fetch_valid !== exp_fv) begin
      n_fail++;
      $display("FAIL %s fetch_valid: got %b want %b", tag, bus.fetch_valid, exp_fv);
    end
    sext = {{(D-8){bus.rel_off[7]}}, bus.rel_off};
    case (m_state)
      M_IDLE, M_HALT: if (bus.req) begin m_state = M_RUN; m_pc = '0; m_cyc = '0; end
      default: begin
        m_cyc = (m_cyc == {CW{1'b1}}) ? m_cyc : m_cyc + 1'b1;
        if (!bus.stall) begin
          if (bus.halt_in)                          m_state = M_HALT;
          else if (bus.absjump_en)                  m_pc = m_lut[bus.lut_addr];
          else if (bus.branch_en && bus.branch_cond) m_pc = m_pc + sext;
          else                                      m_pc = m_pc + 1'b1;
        end
      end
    endcase
    if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
    e.tag = tag; e.pc = m_pc; e.busy = (m_state == M_RUN);
    e.done = (m_state == M_HALT); e.cyc = m_cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_tests++;
    if (bus.prog_ctr !== e.pc) begin
      n_fail++; $display("FAIL %s prog_ctr: got %h want %h", e.tag, bus.prog_ctr, e.pc);
    end
    n_tests++;
    if (bus.busy !== e.busy || bus.done !== e.done) begin
      n_fail++;
      $display("FAIL %s busy/done: got %b/%b want %b/%b", e.tag, bus.busy, bus.done, e.busy, e.done);
    end
    n_tests++;
    if (bus.cycles !== e.cyc) begin
      n_fail++; $display("FAIL %s cycles: got %0d want %0d", e.tag, bus.cycles, e.cyc);
    end
  endtask

  task automatic expect_pc(input string tag, input logic [D-1:0] want);
    n_tests++;
    if (bus.prog_ctr !== want) begin
      n_fail++; $display("FAIL %s literal pc: got %h want %h", tag, bus.prog_ctr, want);
    end
  endtask

  task automatic write_lut(input int idx, input logic [D-1:0] val);
    bus.lut_we = 1; bus.lut_waddr = L'(idx); bus.lut_wdata = val;
    cycle("lut_write");
    bus.lut_we = 0;
  endtask

  task automatic jump_to(input int idx, input logic [D-1:0] val);
    write_lut(idx, val);
    bus.absjump_en = 1; bus.lut_addr = L'(idx);
    cycle("jump_to");
    bus.absjump_en = 0;
    expect_pc("jump_to", val);
  endtask

  task automatic test_reset();
    clear_inputs();
    bus4.req = 0; bus4.stall = 0; bus4.halt_in = 0; bus4.absjump_en = 0;
    bus4.branch_en = 0; bus4.branch_cond = 0; bus4.rel_off = '0;
    bus4.lut_addr = '0; bus4.lut_we = 0; bus4.lut_waddr = '0; bus4.lut_wdata = '0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.prog_ctr !== '0 || bus.busy !== 0 || bus.done !== 0 ||
        bus.fetch_valid !== 0 || bus.cycles !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h busy=%b done=%b fv=%b cyc=%0d want all 0",
               bus.prog_ctr, bus.busy, bus.done, bus.fetch_valid, bus.cycles);
    end
    reset = 1;
  endtask

  task automatic test_start();
    write_lut(3, 10'h155);
    cycle("idle_hold");
    bus.req = 1;
    cycle("start");
    bus.req = 0;
    expect_pc("start", 10'h000);
    for (int i = 1; i <= 3; i++) begin
      cycle("sequential");
      expect_pc("sequential", D'(i));
    end
    bus.req = 1;
    cycle("req_ignored_in_run");
    bus.req = 0;
  endtask

  task automatic test_absjump();
    expect_pc("at_pc4", 10'h004);
    bus.absjump_en = 1; bus.lut_addr = 3;
    bus.branch_en = 1; bus.branch_cond = 1; bus.rel_off = 8'h05;
    cycle("absjump_over_branch");
    expect_pc("absjump_over_branch", 10'h155);
    bus.branch_en = 0; bus.branch_cond = 0;
    bus.lut_we = 1; bus.lut_waddr = 3; bus.lut_wdata = 10'h0AA;
    cycle("jump_same_cycle_write");
    bus.lut_we = 0;
    expect_pc("jump_same_cycle_write", 10'h155);
    cycle("jump_after_write");
    bus.absjump_en = 0;
    expect_pc("jump_after_write", 10'h0AA);
  endtask

  task automatic test_branch();
    jump_to(4, 10'h010);
    bus.branch_en = 1; bus.branch_cond = 1; bus.rel_off = 8'hFC;
    cycle("branch_back");
    expect_pc("branch_back", 10'h00C);
    bus.branch_en = 0;
    jump_to(4, 10'h010);
    bus.branch_en = 1; bus.branch_cond = 0; bus.rel_off = 8'hFC;
    cycle("branch_not_taken");
    expect_pc("branch_not_taken", 10'h011);
    bus.branch_en = 0;
    jump_to(5, 10'h3FE);
    bus.branch_en = 1; bus.branch_cond = 1; bus.rel_off = 8'h05;
    cycle("branch_wrap");
    expect_pc("branch_wrap", 10'h003);
    bus.branch_en = 0; bus.branch_cond = 0;
    jump_to(6, 10'h3FF);
    cycle("seq_wrap");
    expect_pc("seq_wrap", 10'h000);
  endtask

  task automatic test_stall_halt();
    logic [CW-1:0] c0;
    jump_to(7, 10'h007);
    c0 = bus.cycles;
    bus.stall = 1; bus.halt_in = 1; bus.absjump_en = 1;
    for (int i = 0; i < 3; i++) cycle("stall");
    bus.stall = 0; bus.halt_in = 0; bus.absjump_en = 0;
    expect_pc("stall_hold", 10'h007);
    n_tests++;
    if (bus.cycles !== c0 + 16'd3) begin
      n_fail++; $display("FAIL stall_cycles: got %0d want %0d", bus.cycles, c0 + 16'd3);
    end
    cycle("post_stall");
    cycle("post_stall");
    expect_pc("at_pc9", 10'h009);
    bus.halt_in = 1;
    cycle("halt");
    bus.halt_in = 0;
    expect_pc("halt", 10'h009);
    for (int i = 0; i < 2; i++) cycle("halt_frozen");
    bus.req = 1;
    cycle("restart");
    bus.req = 0;
    expect_pc("restart", 10'h000);
  endtask

  task automatic test_async_reset();
    jump_to(8, 10'h020);
    #2;
    reset = 0;
    #1;
    n_tests++;
    if (bus.prog_ctr !== '0 || bus.busy !== 0 || bus.done !== 0 || bus.cycles !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h busy=%b done=%b cyc=%0d want 0",
               bus.prog_ctr, bus.busy, bus.done, bus.cycles);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1;
    bus.req = 1;
    cycle("start_after_reset");
    bus.req = 0;
    cycle("seq_after_reset");
    cycle("seq_after_reset");
    bus.absjump_en = 1; bus.lut_addr = 3;
    cycle("lut_cleared");
    bus.absjump_en = 0;
    expect_pc("lut_cleared", 10'h000);
  endtask

  task automatic test_saturation();
    bus4.req = 1;
    @(posedge clk); #1;
    bus4.req = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 14 || k == 15 || k == 16 || k == 20) begin
        n_tests++;
        if (bus4.cycles !== ((k < 15) ? 4'(k) : 4'd15)) begin
          n_fail++;
          $display("FAIL saturation k=%0d: got %0d want %0d", k, bus4.cycles,
                   (k < 15) ? k : 15);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_absjump();
    test_branch();
    test_stall_halt();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
